// File: rtl/mux_4x1.sv
// 4-to-1 select element: zero-latency combinational output plus a registered shadow
// copy with select-change tracking. Define MUX_4X1_SEL_CNT_EN to enable the select-change counter.
module mux_4x1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic [1:0]       sel_q,
   output logic             sel_chg,
   output logic [7:0]       sel_cnt
);

   logic [1:0] sel;
   logic       sel_diff;

   assign sel      = {s1, s0};
   assign sel_diff = (sel != sel_q);

   // An unknown select propagates X instead of falling back to any input.
   always_comb begin
      y = 'x;
      case (sel)
         2'b00:   y = a;
         2'b01:   y = b;
         2'b10:   y = c;
         2'b11:   y = d;
         default: y = 'x;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         sel_q   <= 2'b00;
         sel_chg <= 1'b0;
      end else begin
         y_q     <= y;
         sel_q   <= sel;
         sel_chg <= sel_diff;
      end
   end

`ifdef MUX_4X1_SEL_CNT_EN
   logic [7:0] sel_cnt_r;

   // Free-running wrap 255 -> 0.
   always_ff @(posedge clk) begin
      if (rst)
         sel_cnt_r <= 8'd0;
      else if (sel_diff)
         sel_cnt_r <= sel_cnt_r + 8'd1;
   end

   assign sel_cnt = sel_cnt_r;
`else
   assign sel_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// Scoreboard bench for mux_4x1: combinational expectations and registered-output
// expectations are queued when stimulus is driven and popped when checked.
module tb_mux_4x1;

`ifdef MUX_4X1_SEL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic       y_q;
      logic [1:0] sel_q;
      logic       chg;
      logic [7:0] cnt;
   } reg_exp_t;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] a = '0, b = '0, c = '0, d = '0;
   logic       s0 = 1'b0, s1 = 1'b0;
   logic [0:0] y, y_q;
   logic [1:0] sel_q;
   logic       sel_chg;
   logic [7:0] sel_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic     q_y[$];
   reg_exp_t q_reg[$];

   logic       m_y_q;
   logic [1:0] m_sel_q;
   logic       m_chg;
   logic [7:0] m_cnt;

   mux_4x1 #(.WIDTH(1)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
      .y(y), .y_q(y_q), .sel_q(sel_q), .sel_chg(sel_chg), .sel_cnt(sel_cnt)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // abcd = {a,b,c,d}
   function automatic logic sel_fn(input logic [3:0] abcd, input logic [1:0] s);
      case (s)
         2'b00:   return abcd[3];
         2'b01:   return abcd[2];
         2'b10:   return abcd[1];
         default: return abcd[0];
      endcase
   endfunction

   task automatic set_inputs(input logic [3:0] abcd, input logic [1:0] s, input logic r);
      {a, b, c, d} = abcd;
      {s1, s0}     = s;
      rst          = r;
   endtask

   // Clock idle: drive inputs, queue expected y, settle 5 ns.
   task automatic drive_comb(input logic [3:0] abcd, input logic [1:0] s);
      set_inputs(abcd, s, rst);
      q_y.push_back(sel_fn(abcd, s));
      #5;
   endtask

   // Clock running: drive inputs, queue expected y and registered state, wait edge + 1.
   task automatic drive_edge(input logic [3:0] abcd, input logic [1:0] s, input logic r);
      reg_exp_t e;
      logic     ey;
      set_inputs(abcd, s, r);
      ey = sel_fn(abcd, s);
      if (r) begin
         m_y_q = 1'b0; m_sel_q = 2'b00; m_chg = 1'b0; m_cnt = 8'd0;
      end else begin
         m_chg = (s != m_sel_q);
         if (m_chg) m_cnt = m_cnt + 8'd1;
         m_sel_q = s;
         m_y_q   = ey;
      end
      e.y_q = m_y_q; e.sel_q = m_sel_q; e.chg = m_chg;
      e.cnt = CNT_EN ? m_cnt : 8'd0;
      q_y.push_back(ey);
      q_reg.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb_sweep();
      logic [3:0] vab[4] = '{4'b0110, 4'b1010, 4'b0001, 4'b1111};
      logic [1:0] vs[4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic       want[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       ey;
      for (int i = 0; i < 4; i++) begin
         drive_comb(vab[i], vs[i]);
         ey = q_y.pop_front();
         n_vec++;
         if (y !== ey || y !== want[i]) begin
            n_err++;
            $display("FAIL comb_sweep[%0d]: y=%b expected %b", i, y, want[i]);
         end
      end
   endtask

   task automatic test_data_change();
      logic [3:0] vab[3] = '{4'b0010, 4'b1110, 4'b1001};
      logic [1:0] vs[3]  = '{2'b00, 2'b01, 2'b11};
      logic       want[3] = '{1'b0, 1'b1, 1'b1};
      logic       ey;
      for (int i = 0; i < 3; i++) begin
         drive_comb(vab[i], vs[i]);
         ey = q_y.pop_front();
         n_vec++;
         if (y !== ey || y !== want[i]) begin
            n_err++;
            $display("FAIL data_change[%0d]: y=%b expected %b", i, y, want[i]);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [5:0] v;
      logic       ey;
      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         drive_comb(v[5:2], v[1:0]);
         ey = q_y.pop_front();
         n_vec++;
         if (y !== ey) begin
            n_err++;
            $display("FAIL exhaustive[%0d]: y=%b expected %b", i, y, ey);
         end
      end
   endtask

   task automatic test_reset();
      reg_exp_t e;
      logic     ey;
      drive_edge(4'b0010, 2'b10, 1'b1);
      ey = q_y.pop_front(); e = q_reg.pop_front();
      n_vec++;
      if (y !== ey || y !== 1'b1) begin
         n_err++; $display("FAIL reset_y: y=%b expected %b", y, 1'b1);
      end
      n_vec++;
      if ({y_q, sel_q, sel_chg, sel_cnt} !== e || {y_q, sel_q, sel_chg, sel_cnt} !== 12'd0) begin
         n_err++;
         $display("FAIL reset_regs: y_q=%b sel_q=%b chg=%b cnt=%0d expected all zero",
                  y_q, sel_q, sel_chg, sel_cnt);
      end
   endtask

   task automatic test_latency();
      logic [1:0] vs[3]   = '{2'b00, 2'b10, 2'b10};
      logic       wchg[3] = '{1'b0, 1'b1, 1'b0};
      reg_exp_t   e;
      logic       ey;
      drive_edge(4'b0000, 2'b00, 1'b1);
      void'(q_y.pop_front()); void'(q_reg.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive_edge(4'b0010, vs[i], 1'b0);
         ey = q_y.pop_front(); e = q_reg.pop_front();
         n_vec++;
         if (y !== ey) begin
            n_err++; $display("FAIL latency_y[%0d]: y=%b expected %b", i, y, ey);
         end
         n_vec++;
         if ({y_q, sel_q, sel_chg, sel_cnt} !== e || sel_chg !== wchg[i]) begin
            n_err++;
            $display("FAIL latency[%0d]: y_q=%b sel_q=%b chg=%b cnt=%0d expected y_q=%b sel_q=%b chg=%b cnt=%0d",
                     i, y_q, sel_q, sel_chg, sel_cnt, e.y_q, e.sel_q, e.chg, e.cnt);
         end
      end
   endtask

   task automatic test_sel_cnt();
      logic [1:0] vs[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      reg_exp_t   e;
      drive_edge(4'b1100, 2'b00, 1'b1);
      void'(q_y.pop_front()); void'(q_reg.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive_edge(4'b1100, vs[i], 1'b0);
         void'(q_y.pop_front()); e = q_reg.pop_front();
         n_vec++;
         if ({y_q, sel_q, sel_chg, sel_cnt} !== e) begin
            n_err++;
            $display("FAIL sel_cnt_step[%0d]: y_q=%b sel_q=%b chg=%b cnt=%0d expected y_q=%b sel_q=%b chg=%b cnt=%0d",
                     i, y_q, sel_q, sel_chg, sel_cnt, e.y_q, e.sel_q, e.chg, e.cnt);
         end
      end
      n_vec++;
      if (sel_cnt !== (CNT_EN ? 8'd4 : 8'd0)) begin
         n_err++;
         $display("FAIL sel_cnt_final: cnt=%0d expected %0d", sel_cnt, CNT_EN ? 4 : 0);
      end
   endtask

   task automatic test_back_to_back();
      reg_exp_t e;
      for (int i = 0; i < 6; i++) begin
         drive_edge(4'b0110, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
         void'(q_y.pop_front()); e = q_reg.pop_front();
         n_vec++;
         if ({y_q, sel_q, sel_chg, sel_cnt} !== e || sel_chg !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: chg=%b sel_q=%b cnt=%0d expected chg=1 sel_q=%b cnt=%0d",
                     i, sel_chg, sel_q, sel_cnt, e.sel_q, e.cnt);
         end
      end
   endtask

   // 260 consecutive changes pushes the counter through its 255 -> 0 wrap.
   task automatic test_wrap_and_mid_reset();
      reg_exp_t e;
      logic     ey;
      for (int i = 0; i < 260; i++) begin
         drive_edge(4'b1001, (i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
         void'(q_y.pop_front()); e = q_reg.pop_front();
         if (i >= 250) begin
            n_vec++;
            if ({y_q, sel_q, sel_chg, sel_cnt} !== e) begin
               n_err++;
               $display("FAIL wrap[%0d]: cnt=%0d chg=%b expected cnt=%0d chg=%b",
                        i, sel_cnt, sel_chg, e.cnt, e.chg);
            end
         end
      end
      drive_edge(4'b0100, 2'b01, 1'b1);
      ey = q_y.pop_front(); e = q_reg.pop_front();
      n_vec++;
      if (y !== ey || {y_q, sel_q, sel_chg, sel_cnt} !== 12'd0) begin
         n_err++;
         $display("FAIL mid_reset: y=%b y_q=%b sel_q=%b chg=%b cnt=%0d expected y=%b regs zero",
                  y, y_q, sel_q, sel_chg, sel_cnt, ey);
      end
   endtask

   task automatic test_random();
      reg_exp_t e;
      logic     ey;
      for (int i = 0; i < 200; i++) begin
         drive_edge(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0));
         ey = q_y.pop_front(); e = q_reg.pop_front();
         n_vec++;
         if (y !== ey || {y_q, sel_q, sel_chg, sel_cnt} !== e) begin
            n_err++;
            $display("FAIL random[%0d]: y=%b y_q=%b sel_q=%b chg=%b cnt=%0d expected y=%b y_q=%b sel_q=%b chg=%b cnt=%0d",
                     i, y, y_q, sel_q, sel_chg, sel_cnt, ey, e.y_q, e.sel_q, e.chg, e.cnt);
         end
      end
   endtask

   initial begin
      m_y_q = 1'b0; m_sel_q = 2'b00; m_chg = 1'b0; m_cnt = 8'd0;
      #2;
      test_comb_sweep();
      test_data_change();
      test_exhaustive();
      clk_run = 1'b1;
      test_reset();
      test_latency();
      test_sel_cnt();
      test_back_to_back();
      test_wrap_and_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
